// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter (dmem_arbiter).
package dmem_arb_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  // Burst counter must hold 0..MAX_BURST inclusive.
  function automatic int burst_w(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_perf.sv
// Saturating performance counter bank for dmem_arbiter (built only with DMEM_ARB_PERF_EN).
module dmem_arb_perf #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc_stall,
  input  logic             inc_dma,
  input  logic             inc_contend,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_dma,
  output logic [CNT_W-1:0] cnt_contend
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_stall   <= '0;
      cnt_dma     <= '0;
      cnt_contend <= '0;
    end else if (clr) begin
      cnt_stall   <= '0;
      cnt_dma     <= '0;
      cnt_contend <= '0;
    end else begin
      if (inc_stall && (cnt_stall != '1))
        cnt_stall <= cnt_stall + 1'b1;
      if (inc_dma && (cnt_dma != '1))
        cnt_dma <= cnt_dma + 1'b1;
      if (inc_contend && (cnt_contend != '1))
        cnt_contend <= cnt_contend + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing dmem between the CPU and DMA ports.
// Optional perf counters are built when DMEM_ARB_PERF_EN is defined.
//
//   owner   | meaning
//   OWN_CPU | CPU won the most recent grant (reset value)
//   OWN_DMA | DMA won the most recent grant
//   burst_cnt counts consecutive grants to owner, saturating at MAX_BURST.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_stall,
  output logic [31:0]      cpu_rdata,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [31:0]      dma_addr,
  input  logic [31:0]      dma_wdata,
  output logic             dma_gnt,
  output logic [31:0]      dma_rdata,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_cpu_stall,
  output logic [CNT_W-1:0] perf_dma_gnt,
  output logic [CNT_W-1:0] perf_contend
`endif
);

  localparam int BW = burst_w(MAX_BURST);

  owner_e        owner;
  logic [BW-1:0] burst_cnt;
  logic          both_req;
  logic          burst_full;
  logic          owner_won;

  always_comb begin
    both_req   = cpu_req & dma_req;
    burst_full = (burst_cnt >= BW'(MAX_BURST));
    cpu_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    // Gating with reset keeps a write from landing while reset is asserted.
    if (reset) begin
      if (both_req) begin
        if ((owner == OWN_CPU) != burst_full) cpu_gnt = 1'b1;
        else                                  dma_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req;
      end
    end
    owner_won = (cpu_gnt && owner == OWN_CPU) || (dma_gnt && owner == OWN_DMA);
  end

  always_comb begin
    mem_we    = dma_gnt ? dma_we    : (cpu_gnt & cpu_we);
    mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
    mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
    cpu_stall = cpu_req & ~cpu_gnt;
    cpu_rdata = mem_rdata;
    dma_rdata = mem_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= OWN_CPU;
      burst_cnt <= '0;
    end else if (cpu_gnt || dma_gnt) begin
      if (owner_won) begin
        if (!burst_full) burst_cnt <= burst_cnt + 1'b1;
      end else begin
        owner     <= dma_gnt ? OWN_DMA : OWN_CPU;
        burst_cnt <= BW'(1);
      end
    end else begin
      burst_cnt <= '0;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  dmem_arb_perf #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .reset       (reset),
    .clr         (perf_clr),
    .inc_stall   (cpu_stall),
    .inc_dma     (dma_gnt),
    .inc_contend (both_req),
    .cnt_stall   (perf_cpu_stall),
    .cnt_dma     (perf_dma_gnt),
    .cnt_contend (perf_contend)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter: MAX_BURST=4 and MAX_BURST=1 instances vs a reference model.
module tb_dmem_arbiter;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_req[2], cpu_we[2], cpu_gnt[2], cpu_stall[2];
  logic        dma_req[2], dma_we[2], dma_gnt[2], mem_we[2];
  logic [31:0] cpu_addr[2], cpu_wdata[2], cpu_rdata[2];
  logic [31:0] dma_addr[2], dma_wdata[2], dma_rdata[2];
  logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];
  logic [31:0] mem[2][64];
  logic [31:0] ref_mem[2][64];

`ifdef DMEM_ARB_PERF_EN
  logic             perf_clr;
  logic [CNT_W-1:0] perf_cpu_stall[2], perf_dma_gnt[2], perf_contend[2];
  int               pm_stall[2], pm_dma[2], pm_cont[2];
`endif

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: last winner (0 cpu, 1 dma) and length of its current run.
  int m_owner[2];
  int m_run[2];
  int mb[2] = '{4, 1};
  int eg[2];
  logic        e_we[2], d_we[2];
  logic [31:0] e_addr[2], e_data[2], d_addr[2], d_data[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(.MAX_BURST(g == 0 ? 4 : 1), .CNT_W(CNT_W)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req[g]),
      .cpu_we    (cpu_we[g]),
      .cpu_addr  (cpu_addr[g]),
      .cpu_wdata (cpu_wdata[g]),
      .cpu_gnt   (cpu_gnt[g]),
      .cpu_stall (cpu_stall[g]),
      .cpu_rdata (cpu_rdata[g]),
      .dma_req   (dma_req[g]),
      .dma_we    (dma_we[g]),
      .dma_addr  (dma_addr[g]),
      .dma_wdata (dma_wdata[g]),
      .dma_gnt   (dma_gnt[g]),
      .dma_rdata (dma_rdata[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
`ifdef DMEM_ARB_PERF_EN
      ,
      .perf_clr       (perf_clr),
      .perf_cpu_stall (perf_cpu_stall[g]),
      .perf_dma_gnt   (perf_dma_gnt[g]),
      .perf_contend   (perf_contend[g])
`endif
    );
  end

  always_comb begin
    for (int g = 0; g < 2; g++) mem_rdata[g] = mem[g][mem_addr[g][7:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int idx;
    idx = $urandom_range(0, 63);
    return {24'h0, idx[5:0], 2'b00};
  endfunction

  task automatic drive(input int g, input logic cr, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cd, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
    cpu_req[g] = cr; cpu_we[g] = cw; cpu_addr[g] = ca; cpu_wdata[g] = cd;
    dma_req[g] = dr; dma_we[g] = dw; dma_addr[g] = da; dma_wdata[g] = dd;
  endtask

  task automatic drive_both(input logic cr, input logic cw, input logic [31:0] ca,
                            input logic [31:0] cd, input logic dr, input logic dw,
                            input logic [31:0] da, input logic [31:0] dd);
    for (int g = 0; g < 2; g++) drive(g, cr, cw, ca, cd, dr, dw, da, dd);
  endtask

  // Called right after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic run_cycle();
    #1;
    for (int g = 0; g < 2; g++) begin
      int e;
      if (!reset) begin
        m_owner[g] = 0;
        m_run[g]   = 0;
`ifdef DMEM_ARB_PERF_EN
        pm_stall[g] = 0; pm_dma[g] = 0; pm_cont[g] = 0;
`endif
      end
      e = 0;
      if (reset) begin
        if (cpu_req[g] && dma_req[g])
          e = (m_run[g] < mb[g]) ? m_owner[g] + 1 : 2 - m_owner[g];
        else if (cpu_req[g]) e = 1;
        else if (dma_req[g]) e = 2;
      end
      eg[g]     = e;
      e_we[g]   = (e == 1) ? cpu_we[g] : (e == 2) ? dma_we[g] : 1'b0;
      e_addr[g] = (e == 2) ? dma_addr[g]  : cpu_addr[g];
      e_data[g] = (e == 2) ? dma_wdata[g] : cpu_wdata[g];
      check($sformatf("cpu_gnt[%0d]", g), cpu_gnt[g], 32'(e == 1));
      check($sformatf("dma_gnt[%0d]", g), dma_gnt[g], 32'(e == 2));
      check($sformatf("cpu_stall[%0d]", g), cpu_stall[g], 32'(cpu_req[g] && e != 1));
      check($sformatf("mem_we[%0d]", g), mem_we[g], 32'(e_we[g]));
      check($sformatf("mem_addr[%0d]", g), mem_addr[g], e_addr[g]);
      check($sformatf("mem_wdata[%0d]", g), mem_wdata[g], e_data[g]);
      if (e == 1 && !e_we[g])
        check($sformatf("cpu_rdata[%0d]", g), cpu_rdata[g], ref_mem[g][e_addr[g][7:2]]);
      if (e == 2 && !e_we[g])
        check($sformatf("dma_rdata[%0d]", g), dma_rdata[g], ref_mem[g][e_addr[g][7:2]]);
`ifdef DMEM_ARB_PERF_EN
      check($sformatf("perf_cpu_stall[%0d]", g), 32'(perf_cpu_stall[g]), 32'(pm_stall[g]));
      check($sformatf("perf_dma_gnt[%0d]", g), 32'(perf_dma_gnt[g]), 32'(pm_dma[g]));
      check($sformatf("perf_contend[%0d]", g), 32'(perf_contend[g]), 32'(pm_cont[g]));
`endif
      d_we[g] = mem_we[g]; d_addr[g] = mem_addr[g]; d_data[g] = mem_wdata[g];
    end
    @(posedge clk);
    for (int g = 0; g < 2; g++) begin
      if (d_we[g]) mem[g][d_addr[g][7:2]] = d_data[g];
      if (!reset) begin
        m_owner[g] = 0;
        m_run[g]   = 0;
      end else if (eg[g] == 0) begin
        m_run[g] = 0;
      end else begin
        if (eg[g] - 1 == m_owner[g]) begin
          m_run[g] = (m_run[g] < mb[g]) ? m_run[g] + 1 : mb[g];
        end else begin
          m_owner[g] = eg[g] - 1;
          m_run[g]   = 1;
        end
        if (e_we[g]) ref_mem[g][e_addr[g][7:2]] = e_data[g];
      end
`ifdef DMEM_ARB_PERF_EN
      if (!reset || perf_clr) begin
        pm_stall[g] = 0; pm_dma[g] = 0; pm_cont[g] = 0;
      end else begin
        if (cpu_req[g] && eg[g] != 1) pm_stall[g] = (pm_stall[g] < 65535) ? pm_stall[g] + 1 : 65535;
        if (eg[g] == 2)               pm_dma[g]   = (pm_dma[g]   < 65535) ? pm_dma[g] + 1   : 65535;
        if (cpu_req[g] && dma_req[g]) pm_cont[g]  = (pm_cont[g]  < 65535) ? pm_cont[g] + 1  : 65535;
      end
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
`ifdef DMEM_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    for (int g = 0; g < 2; g++) begin
      m_owner[g] = 0;
      m_run[g]   = 0;
      for (int i = 0; i < 64; i++) begin
        mem[g][i]     = $urandom;
        ref_mem[g][i] = mem[g][i];
      end
    end
    drive_both(1'b1, 1'b1, 32'h40, 32'h1, 1'b1, 1'b1, 32'h44, 32'h2);
    @(negedge clk);
    run_cycle();
    run_cycle();
    reset = 1'b1;

    // CPU-only stream: writes then reads of 0x10..0x2C.
    for (int i = 0; i < 8; i++) begin
      drive_both(1'b1, 1'b1, 32'h10 + 32'(4 * i), $urandom, 1'b0, 1'b0, 32'h0, 32'h0);
      run_cycle();
    end
    for (int i = 0; i < 8; i++) begin
      drive_both(1'b1, 1'b0, 32'h10 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      run_cycle();
    end

    // Contention from a fresh run: idle cycle, then 12 cycles of both requesting.
    drive_both(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    run_cycle();
    for (int i = 0; i < 12; i++) begin
      drive_both(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
      run_cycle();
    end

    // CPU runs alone until saturated, then DMA arrives.
    drive_both(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    run_cycle();
    for (int i = 0; i < 6; i++) begin
      drive_both(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      run_cycle();
    end
    for (int i = 0; i < 6; i++) begin
      drive_both(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 32'h80 + 32'(4 * i), $urandom);
      run_cycle();
    end

    // DMA write then CPU read-back of 0x40.
    drive_both(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    run_cycle();
    drive_both(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    run_cycle();

    // Reset lands on a DMA write grant mid-burst.
    drive_both(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h44, 32'h11111111);
    run_cycle();
    drive_both(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678);
    reset = 1'b0;
    run_cycle();
    for (int g = 0; g < 2; g++) check($sformatf("mem_0x40_kept[%0d]", g), mem[g][16], 32'hDEADBEEF);
    reset = 1'b1;
    drive_both(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h40, 32'h0BADF00D);
    run_cycle();
    drive_both(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h0BADF00D);
    run_cycle();

`ifdef DMEM_ARB_PERF_EN
    drive_both(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    perf_clr = 1'b1;
    run_cycle();
    perf_clr = 1'b0;
    run_cycle();
`endif

    // Randomized traffic: requesters hold until granted, with occasional drops and resets.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) != 0);
`ifdef DMEM_ARB_PERF_EN
      perf_clr = ($urandom_range(0, 99) == 0);
`endif
      for (int g = 0; g < 2; g++) begin
        if (!cpu_req[g] || eg[g] == 1 || $urandom_range(0, 19) == 0) begin
          cpu_req[g]   = ($urandom_range(0, 99) < 60);
          cpu_we[g]    = $urandom_range(0, 1) == 1;
          cpu_addr[g]  = rand_addr();
          cpu_wdata[g] = $urandom;
        end
        if (!dma_req[g] || eg[g] == 2 || $urandom_range(0, 19) == 0) begin
          dma_req[g]   = ($urandom_range(0, 99) < 50);
          dma_we[g]    = $urandom_range(0, 1) == 1;
          dma_addr[g]  = rand_addr();
          dma_wdata[g] = $urandom;
        end
      end
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
